// File: rtl/ifm_bram_reader.sv
// Tile read initiator for the IFM block RAM: walks a rows x cols window in row-major
// order, absorbs the one-cycle BRAM latency and streams words out with valid/ready.
module ifm_bram_reader #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 32,
    parameter int DIM_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    input  logic [DIM_W-1:0]  row_stride,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH
    } state_t;

    state_t             state;
    logic [DIM_W-1:0]   rows_q;
    logic [DIM_W-1:0]   cols_q;
    logic [DIM_W-1:0]   stride_q;
    logic [WORD_W-1:0]  row_ptr;
    logic [DIM_W-1:0]   col_idx;
    logic [DIM_W-1:0]   row_idx;
    logic [ADDR_W-1:0]  held_addr;

    logic               inflight;
    logic               inflight_last;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic               last_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [WORD_W-1:0]  cur_word;
    logic [CNT_W:0]     occupancy;
    logic               issue;
    logic               final_issue;
    logic               row_end;
    logic               pop;

    // Reads are only issued while every outstanding word is guaranteed a FIFO slot.
    assign cur_word    = row_ptr + WORD_W'(col_idx);
    assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue       = (state == RUN) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign row_end     = (col_idx == cols_q - DIM_W'(1));
    assign final_issue = issue && row_end && (row_idx == rows_q - DIM_W'(1));
    assign pop         = m_valid && m_ready;

    assign rd_en   = issue;
    assign rd_addr = issue ? {cur_word, 2'b00} : held_addr;
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];
    assign m_last  = m_valid && last_mem[rd_ptr];

    // Control FSM and the row/column walkers; tile parameters are frozen at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rows_q    <= '0;
            cols_q    <= '0;
            stride_q  <= '0;
            row_ptr   <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
            held_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        rows_q   <= rows;
                        cols_q   <= cols;
                        stride_q <= row_stride;
                        row_ptr  <= WORD_W'(base_addr >> 2);
                        col_idx  <= '0;
                        row_idx  <= '0;
                        state    <= (rows == '0 || cols == '0) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        held_addr <= {cur_word, 2'b00};
                        if (row_end) begin
                            col_idx <= '0;
                            row_idx <= row_idx + DIM_W'(1);
                            row_ptr <= row_ptr + WORD_W'(stride_q);
                        end else begin
                            col_idx <= col_idx + DIM_W'(1);
                        end
                        if (final_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO: filled from the BRAM the cycle after each issue, drained by the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i]      <= '0;
                last_mem[i] <= 1'b0;
            end
        end else begin
            inflight      <= issue;
            inflight_last <= final_issue;
            if (inflight) begin
                mem[wr_ptr]      <= bram_data;
                last_mem[wr_ptr] <= inflight_last;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({inflight, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_bram_reader.sv
// Self-checking bench for ifm_bram_reader: a BRAM model with one-cycle latency feeds the DUT,
// and every tile is compared against a row-major address/data list built from the tile rules.
module tb_ifm_bram_reader;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int DIM_W  = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  rows;
    logic [DIM_W-1:0]  cols;
    logic [DIM_W-1:0]  row_stride;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] bram_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [DATA_W-1:0] obs_data[$];
    logic              obs_last[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    int obs_done_k, obs_first_k, stall_err, cap_err, gap_err, busy_err, hold_err, max_out, pause_cnt;

    ifm_bram_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .rows(rows), .cols(cols), .row_stride(row_stride),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .bram_data(bram_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] bram_word(input logic [ADDR_W-3:0] w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // BRAM: data for the address presented with rd_en appears one cycle later; junk otherwise.
    always @(posedge clk) begin
        bram_data <= rd_en ? bram_word(rd_addr[ADDR_W-1:2]) : 32'($urandom);
    end

    task automatic build_model(input logic [ADDR_W-1:0] b, input int nr, input int nc, input int ns);
        logic [ADDR_W-3:0] w;
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                w = (ADDR_W-2)'(int'(b >> 2) + r * ns + c);
                exp_addr.push_back({w, 2'b00});
                exp_data.push_back(bram_word(w));
            end
        end
    endtask

    // Launch one tile, then observe cycle k = 1, 2, ... after the start cycle until done.
    task automatic do_tile(input logic [ADDR_W-1:0] b, input int nr, input int nc, input int ns,
                           input int mode, input int restart_k);
        int n, n_iss, n_hs, outst;
        logic prev_stall, rdy;
        logic [DATA_W-1:0] prev_data;
        logic [ADDR_W-1:0] last_iss;
        n = nr * nc;
        obs_addr.delete(); obs_data.delete(); obs_last.delete();
        obs_done_k = -1; obs_first_k = -1;
        stall_err = 0; cap_err = 0; gap_err = 0; busy_err = 0; hold_err = 0;
        max_out = 0; pause_cnt = 0; n_iss = 0; n_hs = 0;
        prev_stall = 1'b0; prev_data = '0; last_iss = '0;
        @(negedge clk);
        base_addr = b; rows = DIM_W'(nr); cols = DIM_W'(nc); row_stride = DIM_W'(ns);
        start = 1'b1; m_ready = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                base_addr = ADDR_W'($urandom); rows = DIM_W'($urandom);
                cols = DIM_W'($urandom); row_stride = DIM_W'($urandom);
            end
            if (k == restart_k) begin
                start = 1'b1; base_addr = 20'h0ABC0; rows = 3; cols = 2; row_stride = 7;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 1) || (k % 4 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            m_ready = rdy;
            outst = n_iss - n_hs;
            if (rd_en) begin
                if (outst >= DEPTH) cap_err++;
                obs_addr.push_back(rd_addr);
                last_iss = rd_addr;
                n_iss++;
            end else begin
                if (n_iss < n && outst < DEPTH) gap_err++;
                if (n_iss < n && outst == DEPTH) pause_cnt++;
                if (n_iss > 0 && rd_addr !== last_iss) hold_err++;
            end
            if (n_iss - n_hs > max_out) max_out = n_iss - n_hs;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_err++;
            if (m_valid && rdy) begin
                if (obs_first_k < 0) obs_first_k = k;
                obs_data.push_back(m_data);
                obs_last.push_back(m_last);
                n_hs++;
            end
            prev_stall = m_valid && !rdy;
            prev_data  = m_data;
            if (done) begin
                obs_done_k = k;
                if (busy !== 1'b0) busy_err++;
                break;
            end else if (busy !== 1'b1) begin
                busy_err++;
            end
        end
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) busy_err++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
        base_addr = '0; rows = '0; cols = '0; row_stride = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, m_valid, m_last} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, rd_en, m_valid, m_last});
        end
        checks++;
        if (rd_addr !== '0 || m_data !== '0) begin
            errors++; $display("[TB] FAIL reset_buses: got rd_addr=%h m_data=%h expected 0/0", rd_addr, m_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, m_valid} !== 4'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset: got %b expected 0000", {busy, done, rd_en, m_valid});
        end
    endtask

    task automatic test_basic;
        build_model(20'h100, 2, 3, 5);
        do_tile(20'h100, 2, 3, 5, 0, -1);
        checks++;
        if (obs_addr.size() != 6 || obs_data.size() != 6) begin
            errors++; $display("[TB] FAIL basic_count: got %0d addr %0d words expected 6/6", obs_addr.size(), obs_data.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 5)) begin
                errors++; $display("[TB] FAIL basic_word%0d: got %h/%h/%b expected %h/%h/%b", i,
                                   obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i], i == 5);
            end
        end
        checks++;
        if (obs_first_k != 3 || obs_done_k != 9) begin
            errors++; $display("[TB] FAIL basic_timing: got first=%0d done=%0d expected 3/9", obs_first_k, obs_done_k);
        end
        checks++;
        if (gap_err + cap_err + busy_err + hold_err != 0) begin
            errors++; $display("[TB] FAIL basic_flow: got gap=%0d cap=%0d busy=%0d hold=%0d expected 0", gap_err, cap_err, busy_err, hold_err);
        end
    endtask

    task automatic test_backpressure;
        int tiles[2][4] = '{'{32'h100, 2, 3, 5}, '{32'h3F0, 3, 5, 6}};
        for (int t = 0; t < 2; t++) begin
            build_model(ADDR_W'(tiles[t][0]), tiles[t][1], tiles[t][2], tiles[t][3]);
            do_tile(ADDR_W'(tiles[t][0]), tiles[t][1], tiles[t][2], tiles[t][3], 1, -1);
            checks++;
            if (obs_addr.size() != exp_addr.size() || obs_data.size() != exp_addr.size()) begin
                errors++; $display("[TB] FAIL bp%0d_count: got %0d/%0d expected %0d", t, obs_addr.size(), obs_data.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size() && i < obs_data.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_addr.size() - 1)) begin
                    errors++; $display("[TB] FAIL bp%0d_word%0d: got %h/%h/%b expected %h/%h", t, i,
                                       obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i]);
                end
            end
            checks++;
            if (stall_err + gap_err + cap_err + busy_err != 0 || max_out != DEPTH || obs_done_k < 0) begin
                errors++; $display("[TB] FAIL bp%0d_flow: got stall=%0d gap=%0d cap=%0d busy=%0d max=%0d done=%0d expected 0/0/0/0/4/seen",
                                   t, stall_err, gap_err, cap_err, busy_err, max_out, obs_done_k);
            end
        end
        checks++;
        if (pause_cnt == 0) begin
            errors++; $display("[TB] FAIL bp_pause: got %0d paused cycles expected nonzero", pause_cnt);
        end
    endtask

    task automatic test_empty;
        for (int t = 0; t < 2; t++) begin
            do_tile(20'h200, t == 0 ? 0 : 3, t == 0 ? 4 : 0, 1, 0, -1);
            checks++;
            if (obs_addr.size() != 0 || obs_data.size() != 0 || obs_done_k != 2 || busy_err != 0) begin
                errors++; $display("[TB] FAIL empty%0d: got rd=%0d words=%0d done=%0d busy_err=%0d expected 0/0/2/0",
                                   t, obs_addr.size(), obs_data.size(), obs_done_k, busy_err);
            end
        end
    endtask

    task automatic test_wrap;
        logic [ADDR_W-1:0] want[4] = '{20'hFFFF8, 20'hFFFFC, 20'h00000, 20'h00004};
        do_tile(20'hFFFF8, 1, 4, 0, 0, -1);
        checks++;
        if (obs_addr.size() != 4 || obs_done_k != 7) begin
            errors++; $display("[TB] FAIL wrap_count: got %0d addr done=%0d expected 4/7", obs_addr.size(), obs_done_k);
        end
        for (int i = 0; i < 4 && i < obs_addr.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_addr[i] !== want[i] || obs_data[i] !== bram_word(want[i][ADDR_W-1:2])) begin
                errors++; $display("[TB] FAIL wrap_word%0d: got %h/%h expected %h", i, obs_addr[i], obs_data[i], want[i]);
            end
        end
    endtask

    task automatic test_restart_ignored;
        build_model(20'h100, 2, 3, 5);
        do_tile(20'h100, 2, 3, 5, 0, 4);
        checks++;
        if (obs_addr.size() != 6 || obs_done_k != 9) begin
            errors++; $display("[TB] FAIL restart_count: got %0d addr done=%0d expected 6/9", obs_addr.size(), obs_done_k);
        end
        for (int i = 0; i < 6 && i < obs_addr.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++; $display("[TB] FAIL restart_word%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL restart_latched: got busy=%b m_valid=%b expected 0/0", busy, m_valid);
        end
    endtask

    task automatic test_mid_reset;
        int hs = 0;
        @(negedge clk);
        base_addr = 20'h100; rows = 2; cols = 3; row_stride = 5; start = 1'b1; m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            m_ready = (k <= 5);
            if (m_valid && m_ready) hs++;
        end
        checks++;
        if (hs != 3 || m_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_setup: got hs=%0d m_valid=%b expected 3/1", hs, m_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, m_valid, m_last} !== 5'b0 || rd_addr !== '0 || m_data !== '0) begin
            errors++; $display("[TB] FAIL midreset_outputs: got %b rd_addr=%h m_data=%h expected 0",
                               {busy, done, rd_en, m_valid, m_last}, rd_addr, m_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        build_model(20'h480, 2, 2, 3);
        do_tile(20'h480, 2, 2, 3, 0, -1);
        checks++;
        if (obs_addr.size() != 4 || obs_data.size() != 4 || obs_done_k != 7) begin
            errors++; $display("[TB] FAIL midreset_fresh: got %0d/%0d done=%0d expected 4/4/7", obs_addr.size(), obs_data.size(), obs_done_k);
        end
        for (int i = 0; i < 4 && i < obs_addr.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == 3)) begin
                errors++; $display("[TB] FAIL midreset_word%0d: got %h/%h/%b expected %h/%h", i, obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [ADDR_W-1:0] b;
        int nr, nc, ns;
        for (int t = 0; t < 6; t++) begin
            b = ADDR_W'($urandom); nr = $urandom_range(1, 3); nc = $urandom_range(1, 5); ns = $urandom_range(0, 9);
            build_model(b, nr, nc, ns);
            do_tile(b, nr, nc, ns, 2, -1);
            checks++;
            if (obs_addr.size() != exp_addr.size() || obs_data.size() != exp_addr.size() || obs_done_k < 0) begin
                errors++; $display("[TB] FAIL rand%0d_count: got %0d/%0d done=%0d expected %0d", t, obs_addr.size(), obs_data.size(), obs_done_k, exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size() && i < obs_data.size(); i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_addr.size() - 1)) begin
                    errors++; $display("[TB] FAIL rand%0d_word%0d: got %h/%h/%b expected %h/%h", t, i,
                                       obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i]);
                end
            end
            checks++;
            if (stall_err + gap_err + cap_err + busy_err + hold_err != 0) begin
                errors++; $display("[TB] FAIL rand%0d_flow: got stall=%0d gap=%0d cap=%0d busy=%0d hold=%0d expected 0",
                                   t, stall_err, gap_err, cap_err, busy_err, hold_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_wrap();
        test_restart_ignored();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
